ace_home_node: RTL and testbench

//  Interconnect-side ACE responder for one cache master plus one snooped peer cache.

---
 rtl/ace_home_node.sv | 256 +++++++++++++++++++++++++
 tb/tb_ace_home_node.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_home_node.sv
// ACE home node: one cache master, one snooped peer, word-wide backing memory.
// Single transaction in flight; reads snoop the peer, writes go straight to memory.
module ace_home_node #(
    parameter int unsigned WIDTH_A = 32,
    parameter int unsigned WIDTH_D = 32
) (
    input  logic               clk,
    input  logic               rst,
    // master read address / data
    input  logic               AR_VALID,
    output logic               AR_READY,
    input  logic [WIDTH_A-1:0] AR_ADDR,
    input  logic               AR_ID,
    input  logic [3:0]         AR_SNOOP,
    output logic               R_VALID,
    input  logic               R_READY,
    output logic [WIDTH_D-1:0] RDATA,
    output logic               R_ID,
    output logic               R_LAST,
    output logic [3:0]         RRESP,
    // master write address / data / response
    input  logic               AW_VALID,
    output logic               AW_READY,
    input  logic [WIDTH_A-1:0] AW_ADDR,
    input  logic               AW_ID,
    input  logic [2:0]         AW_SNOOP,
    input  logic               W_VALID,
    output logic               W_READY,
    input  logic [WIDTH_D-1:0] W_DATA,
    input  logic               W_LAST,
    output logic               B_VALID,
    input  logic               B_READY,
    output logic [1:0]         BRESP,
    output logic               B_ID,
    // peer snoop channels
    output logic               AC_VALID,
    input  logic               AC_READY,
    output logic [WIDTH_A-1:0] AC_ADDR,
    output logic [3:0]         AC_SNOOP,
    output logic [2:0]         AC_PROT,
    input  logic               CR_VALID,
    output logic               CR_READY,
    input  logic [4:0]         CR_RESP,
    input  logic               CD_VALID,
    output logic               CD_READY,
    input  logic [WIDTH_D-1:0] CD_DATA,
    input  logic               CD_LAST,
    // backing memory
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH_A-1:0] mem_addr,
    output logic [WIDTH_D-1:0] mem_wdata,
    input  logic               mem_ack,
    input  logic [WIDTH_D-1:0] mem_rdata
);

    typedef enum logic [3:0] {
        StIdle, StSnpAc, StSnpCr, StSnpCd, StMemWb, StMemRd, StWDat, StMemWr, StRRsp, StBRsp
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_A-1:0]   addr_q, addr_d;
    logic                 id_q, id_d;
    logic                 shared_q, shared_d;     // 1: ReadShared, 0: MakeUnique
    logic                 dirty_q, dirty_d;       // peer passed dirty data
    logic                 err_q, err_d;           // peer reported an error
    logic                 wbad_q, wbad_d;         // unsupported write snoop type
    logic                 rr_q, rr_d;             // 1: AW wins a simultaneous request
    logic [WIDTH_D-1:0]   rdata_q, rdata_d;
    logic [WIDTH_D-1:0]   wdata_q, wdata_d;
    logic [3:0]           rresp_q, rresp_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 grant_ar;

    // Single-beat snoop data; the extra response bit carries nothing we act on.
    logic unused_inputs;
    assign unused_inputs = ^{CD_LAST, CR_RESP[4]};

    assign AC_PROT = 3'b000;

    // State and transaction context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            id_q     <= 1'b0;
            shared_q <= 1'b0;
            dirty_q  <= 1'b0;
            err_q    <= 1'b0;
            wbad_q   <= 1'b0;
            rr_q     <= 1'b0;
            rdata_q  <= '0;
            wdata_q  <= '0;
            rresp_q  <= '0;
            bresp_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            shared_q <= shared_d;
            dirty_q  <= dirty_d;
            err_q    <= err_d;
            wbad_q   <= wbad_d;
            rr_q     <= rr_d;
            rdata_q  <= rdata_d;
            wdata_q  <= wdata_d;
            rresp_q  <= rresp_d;
            bresp_q  <= bresp_d;
        end
    end

    // Next-state, context updates and channel outputs
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        shared_d  = shared_q;
        dirty_d   = dirty_q;
        err_d     = err_q;
        wbad_d    = wbad_q;
        rr_d      = rr_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        rresp_d   = rresp_q;
        bresp_d   = bresp_q;
        AR_READY  = 1'b0;
        AW_READY  = 1'b0;
        W_READY   = 1'b0;
        R_VALID   = 1'b0;
        RDATA     = '0;
        R_ID      = 1'b0;
        R_LAST    = 1'b0;
        RRESP     = '0;
        B_VALID   = 1'b0;
        BRESP     = '0;
        B_ID      = 1'b0;
        AC_VALID  = 1'b0;
        AC_ADDR   = '0;
        AC_SNOOP  = '0;
        CR_READY  = 1'b0;
        CD_READY  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        grant_ar  = AR_VALID && !(AW_VALID && rr_q);

        unique case (state_q)
            StIdle: begin
                if (grant_ar) begin
                    AR_READY = 1'b1;
                    rr_d     = 1'b1;
                    addr_d   = AR_ADDR;
                    id_d     = AR_ID;
                    shared_d = (AR_SNOOP == 4'b0001);
                    rdata_d  = '0;
                    rresp_d  = '0;
                    if (AR_SNOOP == 4'b0001 || AR_SNOOP == 4'b1100) begin
                        state_d = StSnpAc;
                    end else begin
                        rresp_d = 4'b0010;
                        state_d = StRRsp;
                    end
                end else if (AW_VALID) begin
                    AW_READY = 1'b1;
                    rr_d     = 1'b0;
                    addr_d   = AW_ADDR;
                    id_d     = AW_ID;
                    wbad_d   = !(AW_SNOOP == 3'b010 || AW_SNOOP == 3'b000);
                    state_d  = StWDat;
                end
            end
            StSnpAc: begin
                AC_VALID = 1'b1;
                AC_ADDR  = addr_q;
                AC_SNOOP = shared_q ? 4'b0001 : 4'b1101;
                if (AC_READY) state_d = StSnpCr;
            end
            StSnpCr: begin
                CR_READY = 1'b1;
                if (CR_VALID) begin
                    dirty_d = CR_RESP[2];
                    err_d   = CR_RESP[1];
                    rresp_d = {shared_q & CR_RESP[3], 3'b000};
                    if (CR_RESP[0])    state_d = StSnpCd;
                    else if (shared_q) state_d = StMemRd;
                    else               state_d = StRRsp;
                end
            end
            StSnpCd: begin
                CD_READY = 1'b1;
                if (CD_VALID) begin
                    if (!shared_q) begin
                        state_d = StRRsp;
                    end else if (err_q) begin
                        state_d = StMemRd;
                    end else begin
                        rdata_d = CD_DATA;
                        state_d = dirty_q ? StMemWb : StRRsp;
                    end
                end
            end
            StMemWb: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = rdata_q;
                if (mem_ack) state_d = StRRsp;
            end
            StMemRd: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = StRRsp;
                end
            end
            StWDat: begin
                W_READY = 1'b1;
                if (W_VALID) begin
                    wdata_d = W_DATA;
                    if (wbad_q || !W_LAST) begin
                        bresp_d = 2'b10;
                        state_d = StBRsp;
                    end else begin
                        bresp_d = 2'b00;
                        state_d = StMemWr;
                    end
                end
            end
            StMemWr: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) state_d = StBRsp;
            end
            StRRsp: begin
                R_VALID = 1'b1;
                RDATA   = rdata_q;
                R_ID    = id_q;
                R_LAST  = 1'b1;
                RRESP   = rresp_q;
                if (R_READY) state_d = StIdle;
            end
            StBRsp: begin
                B_VALID = 1'b1;
                BRESP   = bresp_q;
                B_ID    = id_q;
                if (B_READY) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ace_home_node.sv
// Bench for ace_home_node: directed transactions, reactive peer/memory agents,
// a transaction-level outcome model and a per-cycle compare process.
module tb_ace_home_node;

    localparam int Budget = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        AR_VALID, AR_READY, AR_ID;
    logic [31:0] AR_ADDR;
    logic [3:0]  AR_SNOOP;
    logic        R_VALID, R_READY, R_ID, R_LAST;
    logic [31:0] RDATA;
    logic [3:0]  RRESP;
    logic        AW_VALID, AW_READY, AW_ID;
    logic [31:0] AW_ADDR;
    logic [2:0]  AW_SNOOP;
    logic        W_VALID, W_READY, W_LAST;
    logic [31:0] W_DATA;
    logic        B_VALID, B_READY, B_ID;
    logic [1:0]  BRESP;
    logic        AC_VALID, AC_READY;
    logic [31:0] AC_ADDR;
    logic [3:0]  AC_SNOOP;
    logic [2:0]  AC_PROT;
    logic        CR_VALID, CR_READY;
    logic [4:0]  CR_RESP;
    logic        CD_VALID, CD_READY, CD_LAST;
    logic [31:0] CD_DATA;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    ace_home_node #(.WIDTH_A(32), .WIDTH_D(32)) dut (
        .clk(clk), .rst(rst),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_ID(AR_ID),
        .AR_SNOOP(AR_SNOOP),
        .R_VALID(R_VALID), .R_READY(R_READY), .RDATA(RDATA), .R_ID(R_ID), .R_LAST(R_LAST),
        .RRESP(RRESP),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_ID(AW_ID),
        .AW_SNOOP(AW_SNOOP),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_LAST(W_LAST),
        .B_VALID(B_VALID), .B_READY(B_READY), .BRESP(BRESP), .B_ID(B_ID),
        .AC_VALID(AC_VALID), .AC_READY(AC_READY), .AC_ADDR(AC_ADDR), .AC_SNOOP(AC_SNOOP),
        .AC_PROT(AC_PROT),
        .CR_VALID(CR_VALID), .CR_READY(CR_READY), .CR_RESP(CR_RESP),
        .CD_VALID(CD_VALID), .CD_READY(CD_READY), .CD_DATA(CD_DATA), .CD_LAST(CD_LAST),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic [31:0] addr; logic id; logic [3:0] snoop;
        logic [4:0] cr; logic [31:0] cd; logic [31:0] memd;
    } rd_stim_t;

    typedef struct packed {
        logic [31:0] addr; logic id; logic [2:0] snoop; logic [31:0] data; logic last;
    } wr_stim_t;

    // Expected outcome of one transaction; mem_kind 0 none, 1 read, 2 write.
    typedef struct packed {
        logic is_read; logic [31:0] addr; logic id;
        logic ac; logic [3:0] ac_snoop;
        logic [1:0] mem_kind; logic [31:0] mem_wdata;
        logic [31:0] rdata; logic [3:0] rresp; logic [1:0] bresp;
        logic [4:0] cr; logic [31:0] cd; logic [31:0] memd;
    } exp_t;

    int       checks = 0;
    int       failures = 0;
    rd_stim_t rd_stim;
    wr_stim_t wr_stim;
    exp_t     act;
    int       ac_delay = 0;
    int       mem_lat = 0;
    int       ac_cnt = 0;
    int       mem_cnt = 0;
    logic     in_txn = 1'b0;
    logic     prefer_aw = 1'b0;
    logic     exp_ch;
    int       ac_hs, mem_hs, b_cycles = 0;
    int       mem_wr_total = 0, mem_rd_total = 0;
    int       grant_log[$];
    logic [31:0] last_mem_waddr, last_mem_wdata, last_ac_addr, last_rdata;
    logic [3:0]  last_ac_snoop, last_rresp;
    logic        last_rid, last_rlast, last_bid;
    logic [1:0]  last_bresp;
    int          last_b_cycles;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model_read(input rd_stim_t s);
        exp_t e;
        e = '0;
        e.is_read = 1'b1; e.addr = s.addr; e.id = s.id;
        e.cr = s.cr; e.cd = s.cd; e.memd = s.memd;
        if (s.snoop == 4'b0001) begin
            e.ac = 1'b1; e.ac_snoop = 4'b0001;
            e.rresp = {s.cr[3], 3'b000};
            if (s.cr[0] && !s.cr[1]) begin
                e.rdata = s.cd;
                if (s.cr[2]) begin e.mem_kind = 2'd2; e.mem_wdata = s.cd; end
            end else begin
                e.mem_kind = 2'd1; e.rdata = s.memd;
            end
        end else if (s.snoop == 4'b1100) begin
            e.ac = 1'b1; e.ac_snoop = 4'b1101;
        end else begin
            e.rresp = 4'b0010;
        end
        return e;
    endfunction

    function automatic exp_t model_write(input wr_stim_t s);
        exp_t e;
        e = '0;
        e.addr = s.addr; e.id = s.id;
        if ((s.snoop == 3'b010 || s.snoop == 3'b000) && s.last) begin
            e.mem_kind = 2'd2; e.mem_wdata = s.data; e.bresp = 2'b00;
        end else begin
            e.bresp = 2'b10;
        end
        return e;
    endfunction

    // Peer and memory: respond according to the active transaction's stimulus.
    initial begin
        AC_READY = 0; CR_VALID = 0; CR_RESP = '0; CD_VALID = 0; CD_DATA = '0; CD_LAST = 0;
        mem_ack = 0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                ac_cnt = 0; mem_cnt = 0;
                AC_READY = 0; CR_VALID = 0; CD_VALID = 0; mem_ack = 0;
            end else begin
                AC_READY = AC_VALID && (ac_cnt >= ac_delay);
                ac_cnt   = AC_VALID ? ac_cnt + 1 : 0;
                CR_VALID = CR_READY; CR_RESP = act.cr;
                CD_VALID = CD_READY; CD_DATA = act.cd; CD_LAST = 1'b1;
                if (mem_req && mem_cnt >= mem_lat) begin
                    mem_ack = 1'b1; mem_rdata = act.memd; mem_cnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_rdata = '0; mem_cnt = mem_req ? mem_cnt + 1 : 0;
                end
            end
        end
    end

    // Compare process: checks every visible channel against the model each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_txn = 1'b0; prefer_aw = 1'b0; b_cycles = 0;
            end else begin
                if (AR_READY || AW_READY) begin
                    exp_ch = (AR_VALID && AW_VALID) ? prefer_aw : !AR_VALID;
                    chk("grant_channel", 32'(AW_READY), 32'(exp_ch));
                    chk("ready_without_valid",
                        32'((AR_READY && !AR_VALID) || (AW_READY && !AW_VALID)), 32'd0);
                    chk("one_in_flight", 32'(in_txn), 32'd0);
                    prefer_aw = !exp_ch;
                    grant_log.push_back(int'(exp_ch));
                    act = exp_ch ? model_write(wr_stim) : model_read(rd_stim);
                    in_txn = 1'b1; ac_hs = 0; mem_hs = 0;
                end
                if (AC_VALID) begin
                    chk("ac_expected", 32'(in_txn && act.ac), 32'd1);
                    chk("ac_addr", AC_ADDR, act.addr);
                    chk("ac_snoop", 32'(AC_SNOOP), 32'(act.ac_snoop));
                    chk("ac_prot", 32'(AC_PROT), 32'd0);
                    if (AC_READY) begin
                        ac_hs++; last_ac_addr = AC_ADDR; last_ac_snoop = AC_SNOOP;
                    end
                end
                if (mem_req) begin
                    chk("mem_expected", 32'(in_txn && act.mem_kind != 2'd0), 32'd1);
                    chk("mem_we", 32'(mem_we), 32'(act.mem_kind == 2'd2));
                    chk("mem_addr", mem_addr, act.addr);
                    if (mem_we) chk("mem_wdata", mem_wdata, act.mem_wdata);
                    if (mem_ack) begin
                        mem_hs++;
                        if (mem_we) begin
                            mem_wr_total++; last_mem_waddr = mem_addr; last_mem_wdata = mem_wdata;
                        end else begin
                            mem_rd_total++;
                        end
                    end
                end
                if (R_VALID) begin
                    chk("r_expected", 32'(in_txn && act.is_read), 32'd1);
                    chk("rdata", RDATA, act.rdata);
                    chk("rresp", 32'(RRESP), 32'(act.rresp));
                    chk("r_id", 32'(R_ID), 32'(act.id));
                    chk("r_last", 32'(R_LAST), 32'd1);
                    if (R_READY) begin
                        chk("r_mem_ops", 32'(mem_hs), 32'(act.mem_kind != 2'd0));
                        chk("r_ac_ops", 32'(ac_hs), 32'(act.ac));
                        last_rdata = RDATA; last_rresp = RRESP; last_rid = R_ID; last_rlast = R_LAST;
                        in_txn = 1'b0;
                    end
                end
                if (B_VALID) begin
                    chk("b_expected", 32'(in_txn && !act.is_read), 32'd1);
                    chk("bresp", 32'(BRESP), 32'(act.bresp));
                    chk("b_id", 32'(B_ID), 32'(act.id));
                    b_cycles++;
                    if (B_READY) begin
                        chk("b_mem_ops", 32'(mem_hs), 32'(act.mem_kind != 2'd0));
                        chk("b_ac_ops", 32'(ac_hs), 32'd0);
                        last_bresp = BRESP; last_bid = B_ID; last_b_cycles = b_cycles;
                        b_cycles = 0; in_txn = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({AR_READY, AW_READY, W_READY, R_VALID, B_VALID, AC_VALID,
                                CR_READY, CD_READY, mem_req, mem_we, R_LAST}), 32'd0);
        chk({tag, "_ids"}, 32'({R_ID, RRESP, BRESP, B_ID, AC_SNOOP, AC_PROT}), 32'd0);
        chk({tag, "_rdata"}, RDATA, 32'd0);
        chk({tag, "_ac_addr"}, AC_ADDR, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic set_rd(input logic [31:0] a, input logic id, input logic [3:0] sn,
                          input logic [4:0] cr, input logic [31:0] cd, input logic [31:0] md);
        rd_stim.addr = a; rd_stim.id = id; rd_stim.snoop = sn;
        rd_stim.cr = cr; rd_stim.cd = cd; rd_stim.memd = md;
    endtask

    task automatic set_wr(input logic [31:0] a, input logic id, input logic [2:0] sn,
                          input logic [31:0] d, input logic last);
        wr_stim.addr = a; wr_stim.id = id; wr_stim.snoop = sn; wr_stim.data = d;
        wr_stim.last = last;
    endtask

    task automatic ar_handshake();
        int n; logic hs;
        AR_VALID = 1'b1; AR_ADDR = rd_stim.addr; AR_ID = rd_stim.id; AR_SNOOP = rd_stim.snoop;
        n = 0; hs = 1'b0;
        while (!hs && n < Budget) begin @(negedge clk); hs = AR_READY; n++; end
        chk("ar_handshake_timeout", 32'(hs), 32'd1);
        @(posedge clk); #1; AR_VALID = 1'b0;
    endtask

    task automatic do_read(input int rdly);
        int n, seen; logic hs;
        ar_handshake();
        n = 0; seen = 0; hs = 1'b0;
        while (!hs && n < Budget) begin
            if (R_VALID) begin if (seen >= rdly) R_READY = 1'b1; seen++; end
            @(negedge clk); hs = R_VALID && R_READY;
            @(posedge clk); #1; R_READY = 1'b0; n++;
        end
        chk("r_handshake_timeout", 32'(hs), 32'd1);
    endtask

    task automatic do_write(input int bdly);
        int n, seen; logic hs;
        AW_VALID = 1'b1; AW_ADDR = wr_stim.addr; AW_ID = wr_stim.id; AW_SNOOP = wr_stim.snoop;
        n = 0; hs = 1'b0;
        while (!hs && n < Budget) begin @(negedge clk); hs = AW_READY; n++; end
        chk("aw_handshake_timeout", 32'(hs), 32'd1);
        @(posedge clk); #1; AW_VALID = 1'b0;
        W_VALID = 1'b1; W_DATA = wr_stim.data; W_LAST = wr_stim.last;
        n = 0; hs = 1'b0;
        while (!hs && n < Budget) begin @(negedge clk); hs = W_READY; n++; end
        chk("w_handshake_timeout", 32'(hs), 32'd1);
        @(posedge clk); #1; W_VALID = 1'b0;
        n = 0; seen = 0; hs = 1'b0;
        while (!hs && n < Budget) begin
            if (B_VALID) begin if (seen >= bdly) B_READY = 1'b1; seen++; end
            @(negedge clk); hs = B_VALID && B_READY;
            @(posedge clk); #1; B_READY = 1'b0; n++;
        end
        chk("b_handshake_timeout", 32'(hs), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int base, mem_before;
        rst = 1'b1;
        AR_VALID = 0; AR_ADDR = '0; AR_ID = 0; AR_SNOOP = '0; R_READY = 0;
        AW_VALID = 0; AW_ADDR = '0; AW_ID = 0; AW_SNOOP = '0;
        W_VALID = 0; W_DATA = '0; W_LAST = 0; B_READY = 0;
        set_rd(32'h0, 1'b0, 4'b0, 5'b0, 32'h0, 32'h0);
        set_wr(32'h0, 1'b0, 3'b0, 32'h0, 1'b0);
        act = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // ReadShared, clean miss in peer, memory answers after 3 wait cycles
        mem_lat = 3;
        set_rd(32'h100, 1'b0, 4'b0001, 5'b00000, 32'h0, 32'hCAFE);
        do_read(0);
        chk("t1_rdata", last_rdata, 32'hCAFE);
        chk("t1_rresp", 32'(last_rresp), 32'h0);
        chk("t1_rlast", 32'(last_rlast), 32'h1);
        chk("t1_mem_reads", 32'(mem_rd_total), 32'd1);

        // ReadShared, peer passes dirty shared data: written back then returned
        mem_lat = 1;
        set_rd(32'h140, 1'b1, 4'b0001, 5'b01101, 32'hBEEF, 32'h0);
        do_read(1);
        chk("t2_wb_addr", last_mem_waddr, 32'h140);
        chk("t2_wb_data", last_mem_wdata, 32'hBEEF);
        chk("t2_rdata", last_rdata, 32'hBEEF);
        chk("t2_rresp", 32'(last_rresp), 32'h8);
        chk("t2_rid", 32'(last_rid), 32'h1);

        // MakeUnique: MakeInvalid snoop, never touches memory
        ac_delay = 2;
        mem_before = mem_wr_total + mem_rd_total;
        set_rd(32'h200, 1'b0, 4'b1100, 5'b00000, 32'h0, 32'h0);
        do_read(2);
        ac_delay = 0;
        chk("t3_ac_addr", last_ac_addr, 32'h200);
        chk("t3_ac_snoop", 32'(last_ac_snoop), 32'hD);
        chk("t3_no_mem", 32'(mem_wr_total + mem_rd_total - mem_before), 32'd0);
        chk("t3_rresp", 32'(last_rresp), 32'h0);

        // WriteClean with B_READY withheld for 4 cycles of B_VALID (handshake on the 5th)
        mem_before = mem_wr_total;
        set_wr(32'h300, 1'b1, 3'b010, 32'h1234, 1'b1);
        do_write(4);
        chk("t4_mem_writes", 32'(mem_wr_total - mem_before), 32'd1);
        chk("t4_wr_addr", last_mem_waddr, 32'h300);
        chk("t4_wr_data", last_mem_wdata, 32'h1234);
        chk("t4_bresp", 32'(last_bresp), 32'h0);
        chk("t4_b_cycles", 32'(last_b_cycles), 32'd5);
        chk("t4_bid", 32'(last_bid), 32'h1);

        // Simultaneous AR/AW, twice: AR first each time
        base = grant_log.size();
        set_rd(32'h400, 1'b1, 4'b0101, 5'b0, 32'h0, 32'h0);
        set_wr(32'h500, 1'b0, 3'b000, 32'h55, 1'b1);
        fork
            do_read(0);
            do_write(0);
        join
        chk("t5_unknown_rresp", 32'(last_rresp), 32'h2);
        chk("t5_unknown_rdata", last_rdata, 32'h0);
        chk("t5_nosnoop_wdata", last_mem_wdata, 32'h55);
        set_rd(32'h600, 1'b0, 4'b0001, 5'b0, 32'h0, 32'h77);
        set_wr(32'h680, 1'b1, 3'b011, 32'h99, 1'b1);
        mem_before = mem_wr_total;
        fork
            do_read(1);
            do_write(0);
        join
        chk("t5_grants", 32'(grant_log.size() - base), 32'd4);
        if (grant_log.size() - base == 4) begin
            chk("t5_grant0", 32'(grant_log[base]), 32'd0);
            chk("t5_grant1", 32'(grant_log[base + 1]), 32'd1);
            chk("t5_grant2", 32'(grant_log[base + 2]), 32'd0);
            chk("t5_grant3", 32'(grant_log[base + 3]), 32'd1);
        end
        chk("t5_bad_snoop_bresp", 32'(last_bresp), 32'h2);
        chk("t5_bad_snoop_nowrite", 32'(mem_wr_total - mem_before), 32'd0);
        chk("t5_rdata", last_rdata, 32'h77);

        // WriteClean missing W_LAST: error response, no memory write
        mem_before = mem_wr_total;
        set_wr(32'h700, 1'b0, 3'b010, 32'hAA, 1'b0);
        do_write(0);
        chk("t6_bresp", 32'(last_bresp), 32'h2);
        chk("t6_nowrite", 32'(mem_wr_total - mem_before), 32'd0);

        // Peer error with data: snoop data dropped, memory read instead
        set_rd(32'h800, 1'b1, 4'b0001, 5'b00011, 32'hDEAD, 32'h4242);
        do_read(0);
        chk("t7_rdata", last_rdata, 32'h4242);
        chk("t7_rresp", 32'(last_rresp), 32'h0);

        // Async reset while the snoop address is pending
        ac_delay = 100;
        set_rd(32'h900, 1'b0, 4'b0001, 5'b0, 32'h0, 32'h1357);
        ar_handshake();
        repeat (3) @(negedge clk);
        chk("t8_ac_pending", 32'(AC_VALID), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("t8_async");
        @(posedge clk); #1;
        check_all_zero("t8_held");
        @(negedge clk); #1 rst = 1'b0; ac_delay = 0;
        @(posedge clk); #1;
        check_all_zero("t8_idle");
        do_read(0);
        chk("t8_rdata", last_rdata, 32'h1357);
        chk("t8_rresp", 32'(last_rresp), 32'h0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
